// File: rtl/mul_div_unit_if.sv
// Request/response bundle between the pipeline and the HI/LO multiply-divide unit.
interface mul_div_unit_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [2:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             flush;
   logic             rd_hi;
   logic             rd_lo;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   logic             busy;
   logic             stall;
   logic             done;
   logic             div_by_zero;

   modport master (
      output start, op, a, b, flush, rd_hi, rd_lo,
      input  hi, lo, busy, stall, done, div_by_zero
   );

   modport slave (
      input  start, op, a, b, flush, rd_hi, rd_lo,
      output hi, lo, busy, stall, done, div_by_zero
   );
endinterface

// File: rtl/mul_div_unit.sv
// HI/LO multiply/divide unit: iterative shift-add multiply and restoring divide on
// operand magnitudes, signs applied in CORR; optional single-cycle multiply.
module mul_div_unit #(
   parameter int WIDTH    = 32,
   parameter bit FAST_MUL = 1'b0
) (
   input logic           clk,
   input logic           rst_n,
   mul_div_unit_if.slave bus
);
   localparam int            CW       = $clog2(WIDTH);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
   localparam logic [2:0]    OP_MULT  = 3'b000;
   localparam logic [2:0]    OP_MULTU = 3'b001;
   localparam logic [2:0]    OP_DIV   = 3'b010;
   localparam logic [2:0]    OP_DIVU  = 3'b011;
   localparam logic [2:0]    OP_MTHI  = 3'b100;
   localparam logic [2:0]    OP_MTLO  = 3'b101;

   typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, CORR = 2'b10} state_t;

   state_t             state_q, state_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0]   opb_q, opb_d, hi_q, hi_d, lo_q, lo_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic               is_div_q, is_div_d, neg_lo_q, neg_lo_d, neg_hi_q, neg_hi_d;
   logic               done_q, done_d, dbz_q, dbz_d;

   logic               signed_op_s, sa_s, sb_s;
   logic [WIDTH-1:0]   a_mag_s, b_mag_s, quo_res_s, rem_res_s;
   logic [2*WIDTH-1:0] fast_prod_s, fast_res_s, prod_res_s;

   // acc = {partial product upper, remaining multiplier}; carry lands in the top bit
   function automatic logic [2*WIDTH-1:0] mul_step(input logic [2*WIDTH-1:0] acc,
                                                   input logic [WIDTH-1:0]   mcand);
      logic [WIDTH:0] t;
      t = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
      return {t, acc[WIDTH-1:1]};
   endfunction

   // acc = {partial remainder, dividend bits / quotient bits}
   function automatic logic [2*WIDTH-1:0] div_step(input logic [2*WIDTH-1:0] acc,
                                                   input logic [WIDTH-1:0]   dvsr);
      logic [WIDTH:0] sh;
      logic [WIDTH:0] diff;
      sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
      diff = sh - {1'b0, dvsr};
      if (!diff[WIDTH]) begin
         return {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      end else begin
         return {sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      end
   endfunction

   // Operand magnitudes and signed results for the fast and committed paths
   always_comb begin
      signed_op_s = (bus.op == OP_MULT) || (bus.op == OP_DIV);
      sa_s        = signed_op_s & bus.a[WIDTH-1];
      sb_s        = signed_op_s & bus.b[WIDTH-1];
      a_mag_s     = sa_s ? -bus.a : bus.a;
      b_mag_s     = sb_s ? -bus.b : bus.b;
      fast_prod_s = {{WIDTH{1'b0}}, a_mag_s} * {{WIDTH{1'b0}}, b_mag_s};
      fast_res_s  = (sa_s ^ sb_s) ? -fast_prod_s : fast_prod_s;
      prod_res_s  = neg_lo_q ? -acc_q : acc_q;
      quo_res_s   = neg_lo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
      rem_res_s   = neg_hi_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
   end

   // FSM next state, datapath step and HI/LO commit
   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      opb_d    = opb_q;
      cnt_d    = cnt_q;
      is_div_d = is_div_q;
      neg_lo_d = neg_lo_q;
      neg_hi_d = neg_hi_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      done_d   = 1'b0;
      dbz_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.flush) begin
               state_d = IDLE;
            end else if (bus.start) begin
               case (bus.op)
                  OP_MULT, OP_MULTU: begin
                     if (FAST_MUL) begin
                        {hi_d, lo_d} = fast_res_s;
                        done_d       = 1'b1;
                     end else begin
                        // the load edge already performs the first step
                        acc_d    = mul_step({{WIDTH{1'b0}}, b_mag_s}, a_mag_s);
                        opb_d    = a_mag_s;
                        cnt_d    = CNT_ONE;
                        is_div_d = 1'b0;
                        neg_lo_d = sa_s ^ sb_s;
                        neg_hi_d = 1'b0;
                        state_d  = RUN;
                     end
                  end
                  OP_DIV, OP_DIVU: begin
                     if (bus.b == {WIDTH{1'b0}}) begin
                        done_d = 1'b1;
                        dbz_d  = 1'b1;
                     end else begin
                        acc_d    = div_step({{WIDTH{1'b0}}, a_mag_s}, b_mag_s);
                        opb_d    = b_mag_s;
                        cnt_d    = CNT_ONE;
                        is_div_d = 1'b1;
                        neg_lo_d = sa_s ^ sb_s;
                        neg_hi_d = sa_s;
                        state_d  = RUN;
                     end
                  end
                  OP_MTHI: hi_d = bus.a;
                  OP_MTLO: lo_d = bus.a;
                  default: state_d = IDLE;
               endcase
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            if (bus.flush) begin
               state_d = IDLE;
            end else begin
               acc_d = is_div_q ? div_step(acc_q, opb_q) : mul_step(acc_q, opb_q);
               cnt_d = cnt_q + CNT_ONE;
               if (cnt_q == CNT_LAST) begin
                  state_d = CORR;
               end else begin
                  state_d = RUN;
               end
            end
         end
         CORR: begin
            if (bus.flush) begin
               state_d = IDLE;
            end else begin
               if (is_div_q) begin
                  hi_d = rem_res_s;
                  lo_d = quo_res_s;
               end else begin
                  {hi_d, lo_d} = prod_res_s;
               end
               done_d  = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and architectural register update
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         acc_q    <= {(2*WIDTH){1'b0}};
         opb_q    <= {WIDTH{1'b0}};
         cnt_q    <= {CW{1'b0}};
         is_div_q <= 1'b0;
         neg_lo_q <= 1'b0;
         neg_hi_q <= 1'b0;
         hi_q     <= {WIDTH{1'b0}};
         lo_q     <= {WIDTH{1'b0}};
         done_q   <= 1'b0;
         dbz_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         opb_q    <= opb_d;
         cnt_q    <= cnt_d;
         is_div_q <= is_div_d;
         neg_lo_q <= neg_lo_d;
         neg_hi_q <= neg_hi_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         done_q   <= done_d;
         dbz_q    <= dbz_d;
      end
   end

   assign bus.hi          = hi_q;
   assign bus.lo          = lo_q;
   assign bus.busy        = (state_q != IDLE);
   assign bus.stall       = (state_q != IDLE) & (bus.rd_hi | bus.rd_lo | bus.start);
   assign bus.done        = done_q;
   assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_mul_div_unit.sv
// Randomized and directed bench for mul_div_unit against an arithmetic reference model.
module tb_mul_div_unit;
   localparam int W = 32;

   logic          clk     = 1'b0;
   logic          rst_n   = 1'b0;
   logic          start   = 1'b0;
   logic          start_f = 1'b0;
   logic          flush   = 1'b0;
   logic          rd_hi   = 1'b0;
   logic          rd_lo   = 1'b0;
   logic [2:0]    op      = 3'b000;
   logic [W-1:0]  a       = 32'h0;
   logic [W-1:0]  b       = 32'h0;
   int            checks  = 0;
   int            errors  = 0;

   mul_div_unit_if #(.WIDTH(W)) s_if ();
   mul_div_unit_if #(.WIDTH(W)) f_if ();

   assign s_if.start = start;
   assign s_if.op    = op;
   assign s_if.a     = a;
   assign s_if.b     = b;
   assign s_if.flush = flush;
   assign s_if.rd_hi = rd_hi;
   assign s_if.rd_lo = rd_lo;
   assign f_if.start = start_f;
   assign f_if.op    = op;
   assign f_if.a     = a;
   assign f_if.b     = b;
   assign f_if.flush = flush;
   assign f_if.rd_hi = rd_hi;
   assign f_if.rd_lo = rd_lo;

   mul_div_unit #(.WIDTH(W), .FAST_MUL(1'b0)) u_slow (.clk(clk), .rst_n(rst_n), .bus(s_if.slave));
   mul_div_unit #(.WIDTH(W), .FAST_MUL(1'b1)) u_fast (.clk(clk), .rst_n(rst_n), .bus(f_if.slave));

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog act=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   // Reference model: plain 64-bit arithmetic; ec = done cycle counted from the start edge
   task automatic model(input logic [2:0] o, input logic [31:0] x, y, ph, pl,
                        output logic [31:0] eh, el, output int ec, output bit ez);
      longint sx, sy, q, r;
      logic [63:0] p;
      eh = ph; el = pl; ec = W + 1; ez = 1'b0;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      case (o)
         3'b000: begin p = sx * sy; eh = p[63:32]; el = p[31:0]; end
         3'b001: begin p = {32'h0, x} * {32'h0, y}; eh = p[63:32]; el = p[31:0]; end
         3'b010: begin
            if (y == 32'h0) begin ec = 1; ez = 1'b1; end
            else begin q = sx / sy; r = sx % sy; el = q[31:0]; eh = r[31:0]; end
         end
         3'b011: begin
            if (y == 32'h0) begin ec = 1; ez = 1'b1; end
            else begin el = x / y; eh = x % y; end
         end
         default: ;
      endcase
   endtask

   function automatic logic [31:0] rnd_opnd();
      case ($urandom_range(0, 5))
         0: return 32'h0000_0000;
         1: return 32'hFFFF_FFFF;
         2: return 32'h8000_0000;
         3: return $urandom_range(0, 20);
         default: return $urandom;
      endcase
   endfunction

   // Issue one op on the iterative unit and follow it to done (bounded)
   task automatic run_slow(input logic [2:0] o, input logic [31:0] x, y,
                           output int dcyc, output bit dbz_seen, output bit busy_ok,
                           output bit early);
      logic [31:0] h0, l0;
      h0 = s_if.hi; l0 = s_if.lo;
      op = o; a = x; b = y; start = 1'b1;
      dcyc = -1; dbz_seen = 1'b0; busy_ok = 1'b1; early = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      for (int c = 1; c <= 40; c++) begin
         if (s_if.done) begin
            dcyc = c; dbz_seen = s_if.div_by_zero;
            if (s_if.busy) busy_ok = 1'b0;
            break;
         end
         if (!s_if.busy) busy_ok = 1'b0;
         if (s_if.hi !== h0 || s_if.lo !== l0) early = 1'b1;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset();
      #2;
      checks++; if (s_if.hi !== 32'h0) begin errors++; $display("FAIL reset_hi act=%h exp=0", s_if.hi); end
      checks++; if (s_if.lo !== 32'h0) begin errors++; $display("FAIL reset_lo act=%h exp=0", s_if.lo); end
      checks++; if ({s_if.busy, s_if.done, s_if.div_by_zero, s_if.stall} !== 4'b0000) begin
         errors++; $display("FAIL reset_flags act=%b exp=0000", {s_if.busy, s_if.done, s_if.div_by_zero, s_if.stall}); end
      #10;
      op = 3'b100; a = 32'hCAFE_0001; start = 1'b1; rst_n = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      checks++; if (s_if.hi !== 32'hCAFE_0001) begin errors++; $display("FAIL first_start_mthi act=%h exp=cafe0001", s_if.hi); end
   endtask

   task automatic test_mt();
      op = 3'b101; a = 32'hA5A5_0002; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      checks++; if (s_if.lo !== 32'hA5A5_0002) begin errors++; $display("FAIL mtlo act=%h exp=a5a50002", s_if.lo); end
      checks++; if (s_if.busy !== 1'b0 || s_if.done !== 1'b0) begin
         errors++; $display("FAIL mt_flags act=%b%b exp=00", s_if.busy, s_if.done); end
      for (int i = 6; i <= 7; i++) begin
         op = 3'(i); a = 32'h1357_9BDF; start = 1'b1;
         @(posedge clk); #1;
         start = 1'b0;
         checks++; if ({s_if.hi, s_if.lo, s_if.busy, s_if.done} !== {32'hCAFE_0001, 32'hA5A5_0002, 2'b00}) begin
            errors++; $display("FAIL noop_%0d act=%h_%h_%b%b exp=cafe0001_a5a50002_00", i, s_if.hi, s_if.lo, s_if.busy, s_if.done); end
      end
   endtask

   task automatic test_directed();
      logic [2:0]  ops [5] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b010};
      logic [31:0] xa  [5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'h7, 32'h8000_0000};
      logic [31:0] xb  [5] = '{32'h2, 32'h2, 32'h2, 32'h2, 32'hFFFF_FFFF};
      logic [31:0] eh  [5] = '{32'hFFFF_FFFF, 32'h1, 32'hFFFF_FFFF, 32'h1, 32'h0};
      logic [31:0] el  [5] = '{32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h3, 32'h8000_0000};
      int dcyc; bit dz, bok, early;
      for (int i = 0; i < 5; i++) begin
         run_slow(ops[i], xa[i], xb[i], dcyc, dz, bok, early);
         checks++; if (dcyc !== 33) begin errors++; $display("FAIL dir%0d_done_cycle act=%0d exp=33", i, dcyc); end
         checks++; if ({s_if.hi, s_if.lo} !== {eh[i], el[i]}) begin
            errors++; $display("FAIL dir%0d_hilo act=%h_%h exp=%h_%h", i, s_if.hi, s_if.lo, eh[i], el[i]); end
         checks++; if (!bok || early || dz) begin
            errors++; $display("FAIL dir%0d_flags act=busyok%0d early%0d dbz%0d exp=100", i, bok, early, dz); end
      end
      @(posedge clk); #1;
      checks++; if (s_if.done !== 1'b0) begin errors++; $display("FAIL done_pulse_width act=%b exp=0", s_if.done); end
   endtask

   task automatic test_fast();
      logic [31:0] x, y, eh, el;
      logic [2:0] o;
      int ec; bit ez;
      for (int i = 0; i < 12; i++) begin
         o = (i < 2) ? 3'(i) : 3'($urandom_range(0, 1));
         x = (i < 2) ? 32'hFFFF_FFFF : rnd_opnd();
         y = (i < 2) ? 32'h2 : rnd_opnd();
         model(o, x, y, 32'h0, 32'h0, eh, el, ec, ez);
         op = o; a = x; b = y; start_f = 1'b1;
         @(posedge clk); #1;
         start_f = 1'b0;
         checks++; if (f_if.done !== 1'b1 || f_if.busy !== 1'b0) begin
            errors++; $display("FAIL fast%0d_timing act=done%b busy%b exp=done1 busy0", i, f_if.done, f_if.busy); end
         checks++; if ({f_if.hi, f_if.lo} !== {eh, el}) begin
            errors++; $display("FAIL fast%0d_hilo act=%h_%h exp=%h_%h", i, f_if.hi, f_if.lo, eh, el); end
      end
   endtask

   task automatic test_random();
      logic [31:0] x, y, eh, el;
      logic [2:0] o;
      int ec, dcyc; bit ez, dz, bok, early;
      for (int i = 0; i < 60; i++) begin
         o = 3'($urandom_range(0, 3));
         x = rnd_opnd();
         y = rnd_opnd();
         model(o, x, y, s_if.hi, s_if.lo, eh, el, ec, ez);
         run_slow(o, x, y, dcyc, dz, bok, early);
         checks++; if (dcyc !== ec) begin errors++; $display("FAIL rnd%0d_done_cycle op=%0d act=%0d exp=%0d", i, o, dcyc, ec); end
         checks++; if ({s_if.hi, s_if.lo} !== {eh, el}) begin
            errors++; $display("FAIL rnd%0d_hilo op=%0d a=%h b=%h act=%h_%h exp=%h_%h", i, o, x, y, s_if.hi, s_if.lo, eh, el); end
         checks++; if (dz !== ez) begin errors++; $display("FAIL rnd%0d_dbz act=%b exp=%b", i, dz, ez); end
         checks++; if (!bok || early) begin errors++; $display("FAIL rnd%0d_busy_visibility act=busyok%0d early%0d exp=10", i, bok, early); end
      end
   endtask

   task automatic test_divzero();
      logic [31:0] h0, l0;
      int dcyc; bit dz, bok, early;
      h0 = s_if.hi; l0 = s_if.lo;
      run_slow(3'b011, 32'h1234_5678, 32'h0, dcyc, dz, bok, early);
      checks++; if (dcyc !== 1 || dz !== 1'b1) begin errors++; $display("FAIL divzero_pulse act=cyc%0d dbz%b exp=cyc1 dbz1", dcyc, dz); end
      checks++; if ({s_if.hi, s_if.lo} !== {h0, l0}) begin
         errors++; $display("FAIL divzero_hilo act=%h_%h exp=%h_%h", s_if.hi, s_if.lo, h0, l0); end
      checks++; if (s_if.busy !== 1'b0) begin errors++; $display("FAIL divzero_busy act=%b exp=0", s_if.busy); end
      @(posedge clk); #1;
      checks++; if ({s_if.done, s_if.div_by_zero, s_if.busy} !== 3'b000) begin
         errors++; $display("FAIL divzero_after act=%b exp=000", {s_if.done, s_if.div_by_zero, s_if.busy}); end
   endtask

   task automatic test_flush();
      logic [31:0] h0, l0;
      int dcyc; bit dz, bok, early, seen;
      h0 = s_if.hi; l0 = s_if.lo; seen = 1'b0;
      op = 3'b000; a = 32'h0BAD_F00D; b = 32'h0000_0777; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int c = 1; c < 10; c++) begin
         seen |= s_if.done;
         @(posedge clk); #1;
      end
      seen |= s_if.done;
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      checks++; if (s_if.busy !== 1'b0 || seen || s_if.done !== 1'b0) begin
         errors++; $display("FAIL flush_run act=busy%b done_seen%b exp=busy0 done_seen0", s_if.busy, seen | s_if.done); end
      checks++; if ({s_if.hi, s_if.lo} !== {h0, l0}) begin
         errors++; $display("FAIL flush_hilo act=%h_%h exp=%h_%h", s_if.hi, s_if.lo, h0, l0); end
      run_slow(3'b011, 32'd9, 32'd4, dcyc, dz, bok, early);
      checks++; if (dcyc !== 33 || {s_if.hi, s_if.lo} !== {32'd1, 32'd2}) begin
         errors++; $display("FAIL after_flush_divu act=cyc%0d %h_%h exp=cyc33 00000001_00000002", dcyc, s_if.hi, s_if.lo); end
      h0 = s_if.hi; l0 = s_if.lo;
      op = 3'b000; a = 32'hFFFF_FFFF; b = 32'h2; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int c = 1; c < 32; c++) begin
         @(posedge clk); #1;
      end
      checks++; if (s_if.busy !== 1'b1 || s_if.done !== 1'b0) begin
         errors++; $display("FAIL corr_cycle act=busy%b done%b exp=busy1 done0", s_if.busy, s_if.done); end
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      checks++; if ({s_if.done, s_if.busy} !== 2'b00 || {s_if.hi, s_if.lo} !== {h0, l0}) begin
         errors++; $display("FAIL flush_corr act=done%b busy%b %h_%h exp=done0 busy0 %h_%h", s_if.done, s_if.busy, s_if.hi, s_if.lo, h0, l0); end
      op = 3'b100; a = 32'hDEAD_BEEF; start = 1'b1; flush = 1'b1;
      @(posedge clk); #1;
      op = 3'b011; a = 32'd100; b = 32'd3;
      @(posedge clk); #1;
      start = 1'b0; flush = 1'b0;
      checks++; if (s_if.hi !== h0 || s_if.busy !== 1'b0 || s_if.done !== 1'b0) begin
         errors++; $display("FAIL flush_start act=hi%h busy%b done%b exp=hi%h busy0 done0", s_if.hi, s_if.busy, s_if.done, h0); end
   endtask

   task automatic test_stall();
      logic [31:0] x, y, eh, el;
      int ec; bit ez, bad, seen;
      x = $urandom; y = $urandom_range(1, 1000);
      model(3'b011, x, y, s_if.hi, s_if.lo, eh, el, ec, ez);
      rd_lo = 1'b1; op = 3'b011; a = x; b = y; start = 1'b1;
      #1;
      checks++; if (s_if.stall !== 1'b0) begin errors++; $display("FAIL stall_idle act=%b exp=0", s_if.stall); end
      @(posedge clk); #1;
      start = 1'b0; bad = 1'b0; seen = 1'b0;
      for (int c = 1; c <= 32; c++) begin
         if (s_if.stall !== 1'b1) bad = 1'b1;
         seen |= s_if.done;
         if (c == 5) begin
            op = 3'b011; a = 32'hFFFF_FFFF; b = 32'h3; start = 1'b1;
         end else begin
            start = 1'b0;
         end
         @(posedge clk); #1;
      end
      start = 1'b0;
      checks++; if (bad || seen) begin errors++; $display("FAIL stall_busy act=bad%b early_done%b exp=00", bad, seen); end
      checks++; if (s_if.done !== 1'b1 || s_if.stall !== 1'b0) begin
         errors++; $display("FAIL stall_done act=done%b stall%b exp=done1 stall0", s_if.done, s_if.stall); end
      checks++; if ({s_if.hi, s_if.lo} !== {eh, el}) begin
         errors++; $display("FAIL ignored_start act=%h_%h exp=%h_%h", s_if.hi, s_if.lo, eh, el); end
      @(posedge clk); #1;
      checks++; if (s_if.busy !== 1'b0) begin errors++; $display("FAIL ignored_start_queued act=busy%b exp=0", s_if.busy); end
      rd_lo = 1'b0;
   endtask

   task automatic test_reset_mid();
      op = 3'b100; a = 32'h1111_1111; start = 1'b1;
      @(posedge clk); #1;
      op = 3'b101; a = 32'h2222_2222;
      @(posedge clk); #1;
      op = 3'b010; a = $urandom; b = 32'h0000_0005;
      @(posedge clk); #1;
      start = 1'b0;
      for (int c = 1; c < 12; c++) begin
         @(posedge clk); #1;
      end
      #2; rst_n = 1'b0; #1;
      checks++; if ({s_if.hi, s_if.lo} !== 64'h0) begin
         errors++; $display("FAIL reset_mid_hilo act=%h_%h exp=0_0", s_if.hi, s_if.lo); end
      checks++; if ({s_if.busy, s_if.done, s_if.stall} !== 3'b000) begin
         errors++; $display("FAIL reset_mid_flags act=%b exp=000", {s_if.busy, s_if.done, s_if.stall}); end
      #2;
      op = 3'b101; a = 32'h0000_1234; start = 1'b1; rst_n = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      checks++; if (s_if.lo !== 32'h0000_1234 || s_if.hi !== 32'h0) begin
         errors++; $display("FAIL mtlo_after_reset act=%h_%h exp=00000000_00001234", s_if.hi, s_if.lo); end
      @(posedge clk); #1;
      checks++; if ({s_if.busy, s_if.done} !== 2'b00) begin
         errors++; $display("FAIL reset_no_done act=%b exp=00", {s_if.busy, s_if.done}); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] eh, el;
      int ec, dcyc; bit ez, dz, bok, early;
      for (int i = 0; i < 3; i++) begin
         model(3'b011, 32'd1000 + 32'(i), 32'd7, s_if.hi, s_if.lo, eh, el, ec, ez);
         run_slow(3'b011, 32'd1000 + 32'(i), 32'd7, dcyc, dz, bok, early);
         checks++; if (dcyc !== 33 || {s_if.hi, s_if.lo} !== {eh, el}) begin
            errors++; $display("FAIL b2b%0d act=cyc%0d %h_%h exp=cyc33 %h_%h", i, dcyc, s_if.hi, s_if.lo, eh, el); end
      end
   endtask

   initial begin
      test_reset();
      test_mt();
      test_directed();
      test_fast();
      test_random();
      test_divzero();
      test_flush();
      test_stall();
      test_reset_mid();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
